// File: rtl/twitchcore_mem_arbiter.sv
// Arbitrates the single-port unified RAM between instruction fetch and load/store.
// Define TWITCHCORE_ARB_RR_EN for round-robin ties; default is data priority with a fetch starvation guard.
module twitchcore_mem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = load/store owns the access
  logic [3:0]          wstrb_q, wstrb_d;
  logic                i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic                i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]         i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                arb_pt, any_req, pick_d;

  assign arb_pt  = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign any_req = i_req | d_req;

`ifdef TWITCHCORE_ARB_RR_EN
  logic last_q, last_d;   // 1 = data was granted last

  assign pick_d = d_req && (!i_req || !last_q);

  always_comb begin
    last_d = last_q;
    if (arb_pt && any_req) last_d = pick_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) last_q <= 1'b0;
    else         last_q <= last_d;
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_q, starve_d;

  assign pick_d = d_req && (!i_req || (starve_q != STARVE_LIM));

  // Any fetch win, or fetch idle at an arbitration point, forgives the backlog.
  always_comb begin
    starve_d = starve_q;
    if (arb_pt) begin
      if (!i_req || !pick_d)          starve_d = '0;
      else if (starve_q != STARVE_LIM) starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wstrb_d     = wstrb_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_wstrb_d = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_IDLE;
        if (owner_q) begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = (wstrb_q == 4'b0000) ? mem_rdata : '0;
        end else begin
          i_rvalid_d = 1'b1;
          i_rdata_d  = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Grant and RAM command are registered here so they appear during ISSUE.
    if (arb_pt && any_req) begin
      state_d    = S_ISSUE;
      owner_d    = pick_d;
      mem_en_d   = 1'b1;
      if (pick_d) begin
        d_gnt_d     = 1'b1;
        wstrb_d     = d_wstrb;
        mem_wstrb_d = d_wstrb;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
      end else begin
        i_gnt_d     = 1'b1;
        wstrb_d     = '0;
        mem_addr_d  = i_addr;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      wstrb_q     <= '0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wstrb_q     <= wstrb_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_twitchcore_mem_arbiter.sv
// Scoreboard bench for twitchcore_mem_arbiter: directed stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them. Honours TWITCHCORE_ARB_RR_EN for grant order.
module tb_twitchcore_mem_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0]   i_rdata, d_rdata;
  logic          mem_en;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  logic [31:0]   ram [0:(1<<AW)-1];

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  typedef struct {
    bit          who;      // 1 = data port
    int          cyc;
    logic [AW-1:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          chk_wd;
  } gnt_t;

  typedef struct {
    bit          who;
    int          cyc;
    logic [31:0] data;
  } rv_t;

  gnt_t exp_g[$];
  rv_t  exp_r[$];

  twitchcore_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data valid the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_g(input bit who, input int c, input logic [AW-1:0] a,
                        input logic [3:0] s, input logic [31:0] wd, input bit cw);
    gnt_t g;
    g.who = who; g.cyc = c; g.addr = a; g.wstrb = s; g.wdata = wd; g.chk_wd = cw;
    exp_g.push_back(g);
  endtask

  task automatic push_r(input bit who, input int c, input logic [31:0] d);
    rv_t r;
    r.who = who; r.cyc = c; r.data = d;
    exp_r.push_back(r);
  endtask

  // Monitor
  always @(negedge clk) begin
    gnt_t g;
    rv_t  r;
    tests++;
    if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid) || (mem_en !== (i_gnt | d_gnt)) ||
        (!mem_en && mem_wstrb != 4'b0)) begin
      failed++;
      $display("FAIL invariant: got ig=%b dg=%b iv=%b dv=%b en=%b ws=%b, want one-hot gnt/rvalid, en==gnt, ws=0 when idle (cyc %0d)",
               i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wstrb, cyc);
    end
    if (i_gnt || d_gnt) begin
      tests++;
      if (exp_g.size() == 0) begin
        failed++;
        $display("FAIL gnt_unexpected: got ig=%b dg=%b, want none (cyc %0d)", i_gnt, d_gnt, cyc);
      end else begin
        g = exp_g.pop_front();
        if (d_gnt != g.who || cyc != g.cyc || mem_addr != g.addr || mem_wstrb != g.wstrb ||
            (g.chk_wd && mem_wdata != g.wdata)) begin
          failed++;
          $display("FAIL gnt: got data=%b cyc=%0d addr=%h ws=%b wd=%h, want data=%b cyc=%0d addr=%h ws=%b wd=%h",
                   d_gnt, cyc, mem_addr, mem_wstrb, mem_wdata, g.who, g.cyc, g.addr, g.wstrb, g.wdata);
        end
      end
    end
    if (i_rvalid || d_rvalid) begin
      tests++;
      if (exp_r.size() == 0) begin
        failed++;
        $display("FAIL rvalid_unexpected: got iv=%b dv=%b, want none (cyc %0d)", i_rvalid, d_rvalid, cyc);
      end else begin
        r = exp_r.pop_front();
        if (d_rvalid != r.who || cyc != r.cyc || (d_rvalid ? d_rdata : i_rdata) != r.data) begin
          failed++;
          $display("FAIL rvalid: got data=%b cyc=%0d rdata=%h, want data=%b cyc=%0d rdata=%h",
                   d_rvalid, cyc, d_rvalid ? d_rdata : i_rdata, r.who, r.cyc, r.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want $finish before time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] outs();
    return {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
            mem_en, mem_wstrb, mem_addr, mem_wdata, busy};
  endfunction

  initial begin
    int t0;
    bit who;
    for (int a = 0; a < (1 << AW); a++) ram[a] = 32'h0;
    ram[14'h010] = 32'hDEADBEEF;
    ram[14'h020] = 32'h11111111;
    ram[14'h030] = 32'h22222222;
    ram[14'h005] = 32'hAAAAAAAA;
    mem_rdata = '0;
    resetn = 1'b0; i_req = 1'b0; d_req = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    step(3);
    chk("reset_outputs", outs(), '0);
    resetn = 1'b1;
    step(1);
    chk("idle_outputs", outs(), '0);

    // Fetch-only read
    t0 = cyc;
    i_req = 1'b1; i_addr = 14'h010;
    push_g(1'b0, t0 + 1, 14'h010, 4'b0000, '0, 1'b0);
    push_r(1'b0, t0 + 3, 32'hDEADBEEF);
    step(1); i_req = 1'b0; chk("busy_issue", busy, 1);
    step(1); chk("busy_wait", busy, 1);
    step(1); chk("busy_done", busy, 0);
    step(2); chk("i_rdata_hold", i_rdata, 32'hDEADBEEF);

    // Simultaneous requests
    t0 = cyc;
    i_req = 1'b1; i_addr = 14'h020;
    d_req = 1'b1; d_addr = 14'h030; d_wstrb = 4'b0000; d_wdata = 32'h0;
    push_g(1'b1, t0 + 1, 14'h030, 4'b0000, 32'h0, 1'b1);
    push_g(1'b0, t0 + 3, 14'h020, 4'b0000, '0, 1'b0);
    push_r(1'b1, t0 + 3, 32'h22222222);
    push_r(1'b0, t0 + 5, 32'h11111111);
    step(1); d_req = 1'b0;
    step(2); i_req = 1'b0;
    step(4);

    // Continuous contention: starvation guard (or round-robin)
    t0 = cyc;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
`ifdef TWITCHCORE_ARB_RR_EN
      who = (k % 2) == 0;
`else
      who = !(k == 4 || k == 9);
`endif
      push_g(who, t0 + 1 + 2*k, who ? 14'h030 : 14'h020, 4'b0000, '0, 1'b0);
      push_r(who, t0 + 3 + 2*k, who ? 32'h22222222 : 32'h11111111);
    end
    step(19); i_req = 1'b0; d_req = 1'b0;
    step(6);

    // Partial store followed back-to-back by a load of the same word
    t0 = cyc;
    d_req = 1'b1; d_addr = 14'h005; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    push_g(1'b1, t0 + 1, 14'h005, 4'b0011, 32'h12345678, 1'b1);
    push_r(1'b1, t0 + 3, 32'h0);
    push_g(1'b1, t0 + 3, 14'h005, 4'b0000, 32'h0, 1'b1);
    push_r(1'b1, t0 + 5, 32'hAAAA5678);
    step(1); d_wdata = 32'h0; d_wstrb = 4'b0000;
    step(2); d_req = 1'b0;
    step(4);

    // Reset while a fetch is in WAIT
    t0 = cyc;
    i_req = 1'b1; i_addr = 14'h010;
    push_g(1'b0, t0 + 1, 14'h010, 4'b0000, '0, 1'b0);
    step(1); i_req = 1'b0;
    step(1); resetn = 1'b0;
    step(1); resetn = 1'b1;
    chk("reset_in_wait_outputs", outs(), '0);
    t0 = cyc;
    i_req = 1'b1; i_addr = 14'h010;
    push_g(1'b0, t0 + 1, 14'h010, 4'b0000, '0, 1'b0);
    push_r(1'b0, t0 + 3, 32'hDEADBEEF);
    step(1); i_req = 1'b0;
    step(5);

    chk("gnt_queue_drained", exp_g.size(), 0);
    chk("rvalid_queue_drained", exp_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/twitchcore_mem_arbiter.md
Name: twitchcore_mem_arbiter

Overview:
Shares the core's single-port unified RAM between two requesters: the instruction-fetch path and the load/store path. Each requester uses a req/gnt/rvalid handshake. The block sequences one RAM access at a time through a small FSM and returns read data with fixed latency. It sits between the twitchcore step sequencer and the RAM instance.

Parameters:
ADDR_W, 14, word-address width into RAM (16K x 32-bit words)
STARVE_MAX, 4, consecutive data-port wins tolerated while fetch waits; legal range 1..255

Ports:
clk  in  1  core clock
resetn  in  1  synchronous active-low reset
i_req  in  1  fetch request; held stable until i_gnt
i_addr  in  ADDR_W  fetch word address
i_gnt  out  1  one-cycle grant pulse to fetch
i_rvalid  out  1  one-cycle fetch response valid
i_rdata  out  32  fetch read data; held until next fetch response
d_req  in  1  load/store request; held stable until d_gnt
d_addr  in  ADDR_W  load/store word address
d_wdata  in  32  store data
d_wstrb  in  4  byte write strobes; 0 = load
d_gnt  out  1  one-cycle grant pulse to load/store
d_rvalid  out  1  one-cycle load/store response (load data or store ack)
d_rdata  out  32  load data; 0 for store acks
mem_en  out  1  RAM access enable
mem_wstrb  out  4  RAM byte write enables
mem_addr  out  ADDR_W  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after mem_en
busy  out  1  high in ISSUE and WAIT

Behaviour:
- Clock is clk. Reset is synchronous and active-low on resetn.
- All outputs are registered. At reset: all outputs are 0, the FSM is in IDLE, the starve counter is 0, and the owner register is 0.
- FSM states:
  - IDLE: if either req is high, arbitrate, latch the winner's addr, wdata and wstrb (fetch wstrb forced to 0), record the owner, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): mem_en=1. mem_addr, mem_wstrb and mem_wdata come from the latched values. The owner's gnt=1. Go to WAIT.
  - WAIT (1 cycle): capture mem_rdata into the owner's rdata register (capture 0 for stores). Schedule the owner's rvalid for the next cycle. Arbitrate again: go to ISSUE if any req is high, otherwise go to IDLE.
- Requests are sampled only in IDLE and WAIT. A req still high in the cycle after gnt counts as a new request.
- Latency: request sampled at T, gnt and mem_en at T+1, rvalid and rdata at T+3.
- Throughput: one access every 2 cycles under continuous requests.
- Arbitration (default): data has fixed priority over fetch.
  - starve_cnt increments on each data win while i_req is high, saturating at STARVE_MAX.
  - starve_cnt clears on a fetch grant or whenever i_req is low at an arbitration point.
  - When starve_cnt==STARVE_MAX and both requesters are active, fetch wins.
- A single requester always wins immediately.
- mem_en and mem_wstrb are 0 outside ISSUE. mem_addr and mem_wdata hold their last value.
- rvalid and gnt never assert for a requester that was not granted. At most one gnt and at most one rvalid is high per cycle.
- Reset mid-operation (in ISSUE or WAIT): the in-flight access is dropped, no rvalid is issued, and the FSM returns to IDLE the next cycle. A store already driven in ISSUE may have been written.

Optional Feature:
TWITCHCORE_ARB_RR_EN
- Defined: round-robin arbitration. On simultaneous requests, the requester not granted last wins. The last-granted register resets to fetch, so data wins the first tie. The starve counter is not built, and STARVE_MAX is ignored.
- Undefined: fixed data priority with the starvation counter, as above.

Test Plan:
- Fetch-only read: RAM[0x010]=0xDEADBEEF, i_req at T with i_addr=0x010 -> i_gnt and mem_en at T+1 with mem_addr=0x010 and mem_wstrb=0; i_rvalid at T+3 with i_rdata=0xDEADBEEF; busy high T+1..T+2.
- Simultaneous requests at T, default build -> d_gnt at T+1, i_gnt at T+3, d_rvalid at T+3, i_rvalid at T+5; never two gnts in one cycle.
- Starvation, STARVE_MAX=4, d_req and i_req held high continuously -> grant order d,d,d,d,i,d,d,d,d,i; starve_cnt returns to 0 after each i grant.
- Partial store: RAM[5]=0xAAAAAAAA, d_addr=5, d_wdata=0x12345678, d_wstrb=4'b0011 -> mem_wstrb=0011 in ISSUE; d_rvalid with d_rdata=0. A following load of addr 5 returns 0xAAAA5678.
- Reset in WAIT: resetn=0 for one cycle during WAIT of a fetch -> next cycle i_rvalid=0 and all outputs 0; a new i_req after reset completes normally with latency 3.
- TWITCHCORE_ARB_RR_EN defined, both requesting continuously from reset -> grant order d,i,d,i,d,i.
